// File: rtl/parking_slot_allocator_if.sv
// Entry/exit handshake and occupancy bundle between the lot controller and the slot allocator.
// The controller side uses modport master; the allocator uses modport slave.
interface parking_slot_allocator_if #(
    parameter int N_SLOTS = 3,
    parameter int SLOT_W  = 2,
    parameter int CNT_W   = 2
);
    logic                entry_req;
    logic                exit_req;
    logic [SLOT_W-1:0]   exit_slot;
    logic                gate_open;
    logic [SLOT_W-1:0]   granted_slot;
    logic                entry_done;
    logic                entry_deny;
    logic                exit_ack;
    logic                exit_err;
    logic [N_SLOTS-1:0]  parked;
    logic [CNT_W-1:0]    empty_count;
    logic                full;

    modport master (
        output entry_req, exit_req, exit_slot,
        input  gate_open, granted_slot, entry_done, entry_deny,
        input  exit_ack, exit_err, parked, empty_count, full
    );

    modport slave (
        input  entry_req, exit_req, exit_slot,
        output gate_open, granted_slot, entry_done, entry_deny,
        output exit_ack, exit_err, parked, empty_count, full
    );
endinterface

// File: rtl/parking_slot_allocator.sv
// Owns the parking occupancy vector: grants the lowest free slot to an entering car,
// holds the gate open for GATE_CYCLES, then commits the slot; exit reports clear slots.
module parking_slot_allocator #(
    parameter int N_SLOTS     = 3,
    parameter int SLOT_W      = 2,
    parameter int CNT_W       = 2,
    parameter int GATE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    parking_slot_allocator_if.slave  bus
);

    localparam int GW = $clog2(GATE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        GATE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t              state_q;
    logic [GW-1:0]       cnt_q;
    logic [SLOT_W-1:0]   granted_slot_q;
    logic [N_SLOTS-1:0]  parked_q;
    logic [N_SLOTS-1:0]  parked_d;
    logic                gate_open_q;
    logic                entry_done_q;
    logic                entry_deny_q;
    logic                exit_ack_q;
    logic                exit_err_q;

    logic                free_found_s;
    logic [SLOT_W-1:0]   free_idx_s;
    logic [N_SLOTS-1:0]  exit_mask_s;
    logic [N_SLOTS-1:0]  commit_mask_s;
    logic                commit_s;
    logic                exit_hit_s;
    logic [CNT_W-1:0]    empty_count_s;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_SLOTS-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < N_SLOTS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Priority encoder: scanning downward lets the lowest free index win.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = {SLOT_W{1'b0}};
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!parked_q[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = SLOT_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    assign commit_s = (state_q == GATE) && (cnt_q == GW'(1));

    // Exit and commit masks; a slot still in GATE is not parked, so its exit is rejected.
    always_comb begin
        exit_mask_s   = {N_SLOTS{1'b0}};
        commit_mask_s = {N_SLOTS{1'b0}};
        for (int i = 0; i < N_SLOTS; i++) begin
            exit_mask_s[i]   = bus.exit_req && (bus.exit_slot == SLOT_W'(i)) && parked_q[i];
            commit_mask_s[i] = commit_s && (granted_slot_q == SLOT_W'(i));
        end
    end

    assign exit_hit_s    = |exit_mask_s;
    assign parked_d      = (parked_q & ~exit_mask_s) | commit_mask_s;
    assign empty_count_s = CNT_W'(N_SLOTS) - popcount(parked_q);

    // Entry FSM, occupancy register and all registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= {GW{1'b0}};
            granted_slot_q <= {SLOT_W{1'b0}};
            parked_q       <= {N_SLOTS{1'b0}};
            gate_open_q    <= 1'b0;
            entry_done_q   <= 1'b0;
            entry_deny_q   <= 1'b0;
            exit_ack_q     <= 1'b0;
            exit_err_q     <= 1'b0;
        end else begin
            parked_q     <= parked_d;
            exit_ack_q   <= exit_hit_s;
            exit_err_q   <= bus.exit_req && !exit_hit_s;
            entry_done_q <= 1'b0;
            entry_deny_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.entry_req) begin
                        state_q <= SEARCH;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SEARCH: begin
                    if (free_found_s) begin
                        granted_slot_q <= free_idx_s;
                        cnt_q          <= GW'(GATE_CYCLES);
                        gate_open_q    <= 1'b1;
                        state_q        <= GATE;
                    end else begin
                        entry_deny_q   <= 1'b1;
                        state_q        <= RELEASE;
                    end
                end
                GATE: begin
                    if (cnt_q == GW'(1)) begin
                        cnt_q        <= {GW{1'b0}};
                        gate_open_q  <= 1'b0;
                        entry_done_q <= 1'b1;
                        state_q      <= RELEASE;
                    end else begin
                        cnt_q        <= cnt_q - GW'(1);
                    end
                end
                RELEASE: begin
                    // A request held past done/deny must drop before another car is considered.
                    if (!bus.entry_req) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= RELEASE;
                    end
                end
                default: begin
                    gate_open_q <= 1'b0;
                    cnt_q       <= {GW{1'b0}};
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.gate_open    = gate_open_q;
    assign bus.granted_slot = granted_slot_q;
    assign bus.entry_done   = entry_done_q;
    assign bus.entry_deny   = entry_deny_q;
    assign bus.exit_ack     = exit_ack_q;
    assign bus.exit_err     = exit_err_q;
    assign bus.parked       = parked_q;
    assign bus.empty_count  = empty_count_s;
    assign bus.full         = (empty_count_s == {CNT_W{1'b0}});

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Scoreboard bench for parking_slot_allocator: entry and exit expectations are queued
// when stimulus is driven and popped when the DUT pulses the matching outputs.
module tb_parking_slot_allocator;

    logic clk;
    logic rst_n;

    parking_slot_allocator_if #(.N_SLOTS(3), .SLOT_W(2), .CNT_W(2)) bus ();

    parking_slot_allocator #(
        .N_SLOTS(3), .SLOT_W(2), .CNT_W(2), .GATE_CYCLES(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       deny;
        logic [1:0] slot;
    } ent_t;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] model_parked;
    ent_t       entry_q[$];
    logic       exit_q[$];
    ent_t       mon_e;
    logic       mon_x;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lowest_free(input logic [2:0] m);
        for (int i = 0; i < 3; i++) begin
            if (!m[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, "_parked"}, bus.parked, model_parked);
        check_eq({tag, "_empty"}, bus.empty_count, 3 - $countones(model_parked));
        check_eq({tag, "_full"}, bus.full, (model_parked == 3'b111));
    endtask

    // One car through the entry handshake; expected slot comes from the bench's own occupancy model.
    task automatic admit(input string tag);
        int   exp_slot;
        int   gates;
        bit   seen;
        ent_t e;
        exp_slot = lowest_free(model_parked);
        e.deny   = (exp_slot < 0);
        e.slot   = (exp_slot < 0) ? 2'd0 : 2'(exp_slot);
        entry_q.push_back(e);
        bus.entry_req = 1'b1;
        gates = 0;
        seen  = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.gate_open) gates++;
            if (bus.entry_done || bus.entry_deny) seen = 1'b1;
        end
        check_eq({tag, "_seen"}, seen, 1);
        if (exp_slot < 0) begin
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (bus.gate_open) gates++;
            end
            check_eq({tag, "_gate"}, gates, 0);
        end else begin
            check_eq({tag, "_gate"}, gates, 4);
            model_parked[exp_slot] = 1'b1;
        end
        bus.entry_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_exit(input int slot);
        logic ack;
        if (slot < 3) ack = model_parked[slot];
        else          ack = 1'b0;
        exit_q.push_back(ack);
        bus.exit_slot = 2'(slot);
        bus.exit_req  = 1'b1;
        @(negedge clk);
        bus.exit_req  = 1'b0;
        if (ack) model_parked[slot] = 1'b0;
    endtask

    // Scoreboard monitor: pops one expectation per observed pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.entry_done || bus.entry_deny) begin
                if (entry_q.size() == 0) begin
                    check_eq("entry_unexpected", {bus.entry_done, bus.entry_deny}, 2'b00);
                end else begin
                    mon_e = entry_q.pop_front();
                    check_eq("entry_kind", {bus.entry_done, bus.entry_deny}, mon_e.deny ? 2'b01 : 2'b10);
                    if (!mon_e.deny) check_eq("grant_slot", bus.granted_slot, mon_e.slot);
                end
            end
            if (bus.exit_ack || bus.exit_err) begin
                if (exit_q.size() == 0) begin
                    check_eq("exit_unexpected", {bus.exit_ack, bus.exit_err}, 2'b00);
                end else begin
                    mon_x = exit_q.pop_front();
                    check_eq("exit_kind", {bus.exit_ack, bus.exit_err}, mon_x ? 2'b10 : 2'b01);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        bus.exit_slot = 2'd0;
        model_parked  = 3'b000;
        repeat (3) @(negedge clk);
        check_state("reset");
        check_eq("reset_gate", bus.gate_open, 0);
        check_eq("reset_pulses", {bus.entry_done, bus.entry_deny, bus.exit_ack, bus.exit_err}, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);

        admit("car0"); check_state("after_car0");
        admit("car1"); check_state("after_car1");
        admit("car2"); check_state("after_car2");

        admit("deny"); check_state("after_deny");

        do_exit(1); check_state("exit1");

        fork
            admit("refill1");
            begin
                repeat (3) @(negedge clk);
                do_exit(1);
            end
        join
        check_state("after_refill1");

        do_exit(3); check_state("exit3");

        do_exit(2); check_state("exit2");
        fork
            admit("car_sim");
            begin
                repeat (5) @(negedge clk);
                do_exit(0);
                check_eq("sim_done", bus.entry_done, 1);
                check_eq("sim_ack", bus.exit_ack, 1);
            end
        join
        check_state("after_sim");

        bus.entry_req = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_gate_pre", bus.gate_open, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_gate_async", bus.gate_open, 0);
        check_eq("rst_parked_async", bus.parked, 3'b000);
        check_eq("rst_no_done", bus.entry_done, 0);
        bus.entry_req = 1'b0;
        model_parked  = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_state("after_rst");
        admit("post_rst"); check_state("after_post_rst");

        repeat (3) @(negedge clk);
        check_eq("sb_drain", entry_q.size() + exit_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
